// File: rtl/dmem_responder.sv
// dmem_responder: load/store target with fixed access latency and a valid/ready response
module dmem_responder #(
   parameter int ADDR_WORDS = 64,
   parameter int LATENCY    = 2
) (
   input  logic        w_clk,
   input  logic        w_rst,
   input  logic        w_req_valid,
   output logic        w_req_ready,
   input  logic        w_req_we,
   input  logic [31:0] w_req_addr,
   input  logic [31:0] w_req_wdata,
   input  logic [1:0]  w_req_size,
   input  logic        w_req_unsigned,
   output logic        w_resp_valid,
   input  logic        w_resp_ready,
   output logic [31:0] w_resp_rdata,
   output logic        w_resp_err
);
   localparam int IW = $clog2(ADDR_WORDS);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, next;
   logic [3:0] cnt;
   logic we_q, uns_q;
   logic [31:0] addr_q, wdata_q;
   logic [1:0] size_q;
   logic [31:0] mem [ADDR_WORDS] = '{default: '0};
   logic [IW-1:0] idx;
   logic [31:0] word, load, wide;
   logic [7:0] byte_v;
   logic [15:0] half_v;
   logic [3:0] be;
   logic err, commit;
   always_ff @(posedge w_clk)
      state <= w_rst ? IDLE : next;
   always_comb
      next = state == IDLE ? (w_req_valid ? WAIT : IDLE) :
             state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) :
             state == RESP ? (w_resp_ready ? IDLE : RESP) : IDLE;
   always_comb begin
      w_req_ready  = state == IDLE;
      w_resp_valid = state == RESP;
   end
   always_comb begin
      commit = state == WAIT && cnt == 4'd0;
      idx    = addr_q[IW+1:2];
      err    = size_q == 2'b11 || (size_q == 2'b01 && addr_q[0]) ||
               (size_q == 2'b10 && addr_q[1:0] != 2'b00) || addr_q >= 32'(ADDR_WORDS * 4);
      word   = mem[idx];
      byte_v = word[{addr_q[1:0], 3'b000} +: 8];
      half_v = word[{addr_q[1], 4'b0000} +: 16];
      load   = size_q == 2'b00 ? {{24{~uns_q & byte_v[7]}}, byte_v} :
               size_q == 2'b01 ? {{16{~uns_q & half_v[15]}}, half_v} : word;
      be     = size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
               size_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wide   = size_q == 2'b00 ? {4{wdata_q[7:0]}} :
               size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
   end
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         cnt          <= 4'd0;
         w_resp_rdata <= 32'd0;
         w_resp_err   <= 1'b0;
      end else begin
         if (state == IDLE && w_req_valid) begin
            we_q    <= w_req_we;
            addr_q  <= w_req_addr;
            wdata_q <= w_req_wdata;
            size_q  <= w_req_size;
            uns_q   <= w_req_unsigned;
            cnt     <= 4'(LATENCY - 1);
         end else if (state == WAIT && cnt != 4'd0)
            cnt <= cnt - 4'd1;
         if (commit) begin
            w_resp_rdata <= (err || we_q) ? 32'd0 : load;
            w_resp_err   <= err;
         end else if (state == RESP && w_resp_ready) begin
            w_resp_rdata <= 32'd0;
            w_resp_err   <= 1'b0;
         end
      end
   end
   // Storage is deliberately outside reset; reset only blocks a pending commit.
   always_ff @(posedge w_clk)
      if (!w_rst && commit && we_q && !err)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wide[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random load/store traffic checked against a word-array model
module tb_dmem_responder;
   localparam int AW = 64, LAT = 2;
   logic w_clk = 0, w_rst = 1, w_req_valid = 0, w_req_ready, w_req_we = 0, w_req_unsigned = 0;
   logic [31:0] w_req_addr = 0, w_req_wdata = 0, w_resp_rdata;
   logic [1:0] w_req_size = 0;
   logic w_resp_valid, w_resp_ready = 1, w_resp_err;
   int errors = 0, checks = 0;
   logic [31:0] mem_m [AW];

   dmem_responder #(.ADDR_WORDS(AW), .LATENCY(LAT)) dut (
      .w_clk(w_clk), .w_rst(w_rst), .w_req_valid(w_req_valid), .w_req_ready(w_req_ready),
      .w_req_we(w_req_we), .w_req_addr(w_req_addr), .w_req_wdata(w_req_wdata),
      .w_req_size(w_req_size), .w_req_unsigned(w_req_unsigned), .w_resp_valid(w_resp_valid),
      .w_resp_ready(w_resp_ready), .w_resp_rdata(w_resp_rdata), .w_resp_err(w_resp_err));

   always #5 w_clk = ~w_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: byte-granular arithmetic on a word array, sign extension by subtraction.
   task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns, output logic [31:0] rd, output logic er);
      int unsigned nb = 1 << sz;
      int unsigned sh = 8 * (addr % 4);
      longint unsigned mask, lane;
      er = sz == 2'b11 || addr % nb != 0 || addr >= AW * 4;
      rd = 0;
      if (er) return;
      mask = ((64'd1 << (8 * nb)) - 1) << sh;
      if (we)
         mem_m[addr / 4] = 32'((longint'(mem_m[addr / 4]) & ~mask) | ((longint'(wd) << sh) & mask));
      else begin
         lane = (longint'(mem_m[addr / 4]) & mask) >> sh;
         if (!uns && nb < 4 && ((lane >> (8 * nb - 1)) & 1) == 1) lane = lane - (64'd1 << (8 * nb));
         rd = 32'(lane);
      end
   endtask

   task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns, input int hold, input string tag);
      logic [31:0] erd;
      logic eer;
      int n;
      model(we, addr, wd, sz, uns, erd, eer);
      @(negedge w_clk);
      chk({tag, ":req_ready_idle"}, 32'(w_req_ready), 1);
      w_req_valid = 1; w_req_we = we; w_req_addr = addr; w_req_wdata = wd;
      w_req_size = sz; w_req_unsigned = uns; w_resp_ready = (hold == 0);
      @(posedge w_clk); #1;
      w_req_valid = 0; w_req_we = 1'($urandom); w_req_addr = $urandom; w_req_wdata = $urandom;
      w_req_size = 2'($urandom); w_req_unsigned = 1'($urandom);
      chk({tag, ":req_ready_busy"}, 32'(w_req_ready), 0);
      n = 0;
      while (!w_resp_valid && n < 20) begin
         @(posedge w_clk); #1;
         n++;
      end
      chk({tag, ":latency"}, n, LAT);
      chk({tag, ":rdata"}, w_resp_rdata, erd);
      chk({tag, ":err"}, 32'(w_resp_err), 32'(eer));
      for (int i = 0; i < hold; i++) begin
         @(posedge w_clk); #1;
         chk({tag, ":hold_valid"}, 32'(w_resp_valid), 1);
         chk({tag, ":hold_rdata"}, w_resp_rdata, erd);
         chk({tag, ":hold_err"}, 32'(w_resp_err), 32'(eer));
         chk({tag, ":hold_req_ready"}, 32'(w_req_ready), 0);
      end
      w_resp_ready = 1;
      @(posedge w_clk); #1;
      chk({tag, ":valid_cleared"}, 32'(w_resp_valid), 0);
      chk({tag, ":rdata_cleared"}, w_resp_rdata, 0);
      chk({tag, ":err_cleared"}, 32'(w_resp_err), 0);
      chk({tag, ":back_to_idle"}, 32'(w_req_ready), 1);
   endtask

   initial begin
      for (int i = 0; i < AW; i++) mem_m[i] = 0;
      repeat (2) @(posedge w_clk);
      #1;
      chk("rst_req_ready", 32'(w_req_ready), 1);
      chk("rst_resp_valid", 32'(w_resp_valid), 0);
      chk("rst_rdata", w_resp_rdata, 0);
      chk("rst_err", 32'(w_resp_err), 0);
      w_rst = 0;
      xact(1, 8, 32'hDEADBEEF, 2'b10, 0, 0, "st_w8");
      xact(0, 8, 0, 2'b10, 0, 0, "ld_w8");
      xact(1, 13, 32'h80, 2'b00, 0, 0, "st_b13");
      xact(0, 13, 0, 2'b00, 0, 0, "ld_b13_s");
      xact(0, 13, 0, 2'b00, 1, 0, "ld_b13_u");
      xact(0, 12, 0, 2'b10, 0, 0, "ld_w12");
      xact(1, 4, 32'hAABBCCDD, 2'b10, 0, 0, "st_w4");
      xact(1, 6, 32'h1234, 2'b01, 0, 0, "st_h6");
      xact(0, 4, 0, 2'b10, 1, 0, "ld_w4");
      xact(0, 6, 0, 2'b01, 0, 0, "ld_h6_s");
      xact(0, 2, 0, 2'b10, 0, 0, "err_ld_w2");
      xact(1, 5, 32'hFFFF, 2'b01, 0, 0, "err_st_h5");
      xact(1, 4, 32'h5555, 2'b11, 0, 0, "err_size3");
      xact(0, 256, 0, 2'b10, 0, 0, "err_ld_256");
      xact(1, 256, 32'h77, 2'b00, 0, 0, "err_st_256");
      xact(0, 32'hFFFF_FFFC, 0, 2'b10, 0, 0, "err_ld_top");
      xact(0, 0, 0, 2'b10, 0, 0, "ld_w0_after_err");
      xact(0, 4, 0, 2'b10, 0, 0, "ld_w4_after_err");
      xact(0, 8, 0, 2'b10, 0, 5, "hold_ld_w8");
      xact(1, 0, 32'hCAFEF00D, 2'b10, 0, 0, "st_w0");
      @(negedge w_clk);
      w_req_valid = 1; w_req_we = 1; w_req_addr = 0; w_req_wdata = 32'h11111111;
      w_req_size = 2'b10; w_resp_ready = 1;
      @(posedge w_clk); #1;
      w_req_valid = 0; w_rst = 1;
      @(posedge w_clk); #1;
      w_rst = 0;
      chk("rst_wait_req_ready", 32'(w_req_ready), 1);
      chk("rst_wait_resp_valid", 32'(w_resp_valid), 0);
      for (int i = 0; i < LAT + 2; i++) begin
         @(posedge w_clk); #1;
         chk("rst_wait_no_resp", 32'(w_resp_valid), 0);
      end
      xact(0, 0, 0, 2'b10, 0, 0, "ld_w0_after_rst");
      for (int k = 0; k < 80; k++)
         xact(1'($urandom), 32'($urandom_range(0, 263)), $urandom, 2'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0) ? 3 : 0, "rand");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
